// File: rtl/sd_cmd_phy.sv
// SD card CMD-line PHY: serialises a 48-bit command frame with CRC7 and
// optionally collects a 48-bit response, handshaking with cmdcontrol.
module sd_cmd_phy #(
  parameter int RESP_TIMEOUT = 64,
  parameter bit RESP_EN      = 1'b1
) (
  input  logic        iClock_host,
  input  logic        iReset,
  input  logic        iStrobe_in,
  input  logic [37:0] iCmd_in,
  output logic        oAck_out,
  output logic        oStrobe_out,
  input  logic        iAck_in,
  input  logic        iIdle_in,
  output logic [37:0] oResponse,
  input  logic        iSd_cmd,
  output logic        oSd_cmd,
  output logic        oSd_cmd_oe,
  output logic        oCrc_error,
  output logic        oTimeout
);

  localparam int TW = $clog2(RESP_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(RESP_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ACK       = 3'd1,
    SEND      = 3'd2,
    WAIT_RESP = 3'd3,
    RECV      = 3'd4,
    DELIVER   = 3'd5,
    DONE      = 3'd6
  } state_t;

  // CRC7, polynomial x^7 + x^3 + 1, MSB-first, zero init.
  function automatic logic [6:0] crc7_calc(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = 7'd0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  state_t          r_state, w_state;
  logic [37:0]     r_cmd, w_cmd;
  logic [47:0]     r_shift, w_shift;
  logic [46:0]     r_rx, w_rx;
  logic [5:0]      r_bit_cnt, w_bit_cnt;
  logic [TW-1:0]   r_tmr, w_tmr;
  logic            r_sd_cmd, w_sd_cmd;
  logic            r_oe, w_oe;
  logic            r_ack, w_ack;
  logic            r_strobe, w_strobe;
  logic [37:0]     r_resp, w_resp;
  logic            r_crc_err, w_crc_err;
  logic            r_tmo, w_tmo;

  logic [47:0]     w_frame;
  logic [47:0]     w_rx_full;
  logic            w_rx_crc_bad;

  assign w_frame      = {2'b01, r_cmd, crc7_calc({2'b01, r_cmd}), 1'b1};
  assign w_rx_full    = {r_rx, iSd_cmd};
  assign w_rx_crc_bad = (crc7_calc(w_rx_full[47:8]) != w_rx_full[7:1]);

  always_comb begin
    w_state   = r_state;
    w_cmd     = r_cmd;
    w_shift   = r_shift;
    w_rx      = r_rx;
    w_bit_cnt = r_bit_cnt;
    w_tmr     = r_tmr;
    w_sd_cmd  = r_sd_cmd;
    w_oe      = r_oe;
    w_ack     = r_ack;
    w_strobe  = r_strobe;
    w_resp    = r_resp;
    w_crc_err = r_crc_err;
    w_tmo     = r_tmo;
    // Abort outranks every other transition.
    if (iIdle_in && (r_state != IDLE)) begin
      w_state   = IDLE;
      w_oe      = 1'b0;
      w_sd_cmd  = 1'b1;
      w_ack     = 1'b0;
      w_strobe  = 1'b0;
      w_crc_err = 1'b0;
      w_tmo     = 1'b0;
      w_bit_cnt = 6'd0;
      w_tmr     = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (iStrobe_in) begin
            w_cmd   = iCmd_in;
            w_ack   = 1'b1;
            w_state = ACK;
          end else begin
            w_state = IDLE;
          end
        end
        ACK: begin
          if (!iStrobe_in) begin
            w_ack     = 1'b0;
            w_state   = SEND;
            w_sd_cmd  = w_frame[47];
            w_shift   = {w_frame[46:0], 1'b0};
            w_oe      = 1'b1;
            w_bit_cnt = 6'd0;
            w_crc_err = 1'b0;
            w_tmo     = 1'b0;
          end else begin
            w_state = ACK;
          end
        end
        SEND: begin
          if (r_bit_cnt == 6'd47) begin
            w_oe      = 1'b0;
            w_sd_cmd  = 1'b1;
            w_bit_cnt = 6'd0;
            w_tmr     = '0;
            if (RESP_EN) begin
              w_state = WAIT_RESP;
            end else begin
              w_state  = DELIVER;
              w_strobe = 1'b1;
              w_resp   = 38'd0;
            end
          end else begin
            w_sd_cmd  = r_shift[47];
            w_shift   = {r_shift[46:0], 1'b0};
            w_bit_cnt = r_bit_cnt + 6'd1;
          end
        end
        WAIT_RESP: begin
          if (!iSd_cmd) begin
            w_state   = RECV;
            w_rx      = 47'd0;
            w_bit_cnt = 6'd0;
          end else if (r_tmr == TMO_LAST) begin
            w_state  = DELIVER;
            w_strobe = 1'b1;
            w_tmo    = 1'b1;
            w_resp   = 38'd0;
          end else begin
            w_tmr = r_tmr + TW'(1);
          end
        end
        RECV: begin
          // The 47th sample (end bit) completes the frame; it is not checked.
          if (r_bit_cnt == 6'd46) begin
            w_state   = DELIVER;
            w_strobe  = 1'b1;
            w_resp    = w_rx_full[45:8];
            w_crc_err = w_rx_crc_bad;
          end else begin
            w_rx      = {r_rx[45:0], iSd_cmd};
            w_bit_cnt = r_bit_cnt + 6'd1;
          end
        end
        DELIVER: begin
          if (iAck_in) begin
            w_strobe = 1'b0;
            w_state  = DONE;
          end else begin
            w_state = DELIVER;
          end
        end
        DONE: begin
          if (!iAck_in) begin
            w_state = IDLE;
          end else begin
            w_state = DONE;
          end
        end
        default: begin
          w_state  = IDLE;
          w_oe     = 1'b0;
          w_sd_cmd = 1'b1;
          w_ack    = 1'b0;
          w_strobe = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge iClock_host or negedge iReset) begin
    if (!iReset) begin
      r_state   <= IDLE;
      r_cmd     <= 38'd0;
      r_shift   <= 48'd0;
      r_rx      <= 47'd0;
      r_bit_cnt <= 6'd0;
      r_tmr     <= '0;
      r_sd_cmd  <= 1'b1;
      r_oe      <= 1'b0;
      r_ack     <= 1'b0;
      r_strobe  <= 1'b0;
      r_resp    <= 38'd0;
      r_crc_err <= 1'b0;
      r_tmo     <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cmd     <= w_cmd;
      r_shift   <= w_shift;
      r_rx      <= w_rx;
      r_bit_cnt <= w_bit_cnt;
      r_tmr     <= w_tmr;
      r_sd_cmd  <= w_sd_cmd;
      r_oe      <= w_oe;
      r_ack     <= w_ack;
      r_strobe  <= w_strobe;
      r_resp    <= w_resp;
      r_crc_err <= w_crc_err;
      r_tmo     <= w_tmo;
    end
  end

  assign oAck_out    = r_ack;
  assign oStrobe_out = r_strobe;
  assign oResponse   = r_resp;
  assign oSd_cmd     = r_sd_cmd;
  assign oSd_cmd_oe  = r_oe;
  assign oCrc_error  = r_crc_err;
  assign oTimeout    = r_tmo;

endmodule
